// File: rtl/fb_swap_arbiter.sv
// Round-robin two-requester write arbiter into a double-buffered frame buffer,
// with bank swap deferred to the next new-frame pulse.
module fb_swap_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int FB_DEPTH = 57600
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [1:0]        req_valid_in,
    input  logic [ADDR_W-1:0] req_addr0_in,
    input  logic [ADDR_W-1:0] req_addr1_in,
    input  logic [DATA_W-1:0] req_data0_in,
    input  logic [DATA_W-1:0] req_data1_in,
    output logic [1:0]        req_ready_out,
    output logic              wr_en_out,
    output logic [ADDR_W:0]   wr_addr_out,
    output logic [DATA_W-1:0] wr_data_out,
    input  logic              swap_req_in,
    input  logic              nf_in,
    output logic              front_sel_out,
    output logic              swap_busy_out,
    output logic              swap_done_out,
    output logic              drop_out
);

    typedef enum logic {IDLE, SWAP_PEND} state_t;

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(FB_DEPTH);

    state_t            state, state_next;
    logic              ptr;
    logic [1:0]        grant;
    logic              fire;
    logic              sel;
    logic              swap_fire;
    logic              in_range;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant      = '0;
        swap_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid_in[ptr])       grant[ptr]  = 1'b1;
                else if (req_valid_in[~ptr]) grant[~ptr] = 1'b1;
                if (swap_req_in) state_next = SWAP_PEND;
            end
            SWAP_PEND: begin
                if (nf_in) begin
                    state_next = IDLE;
                    swap_fire  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign fire     = |grant;
    assign sel      = grant[1];
    assign sel_addr = sel ? req_addr1_in : req_addr0_in;
    assign sel_data = sel ? req_data1_in : req_data0_in;
    assign in_range = {1'b0, sel_addr} < DEPTH;

    // Grant is combinational, so it must be masked explicitly while reset is held.
    assign req_ready_out = rst_in ? grant : '0;
    assign swap_busy_out = (state == SWAP_PEND);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ptr           <= 1'b0;
            front_sel_out <= 1'b0;
            swap_done_out <= 1'b0;
            wr_en_out     <= 1'b0;
            drop_out      <= 1'b0;
            wr_addr_out   <= '0;
            wr_data_out   <= '0;
        end else begin
            if (fire) ptr <= ~sel;
            front_sel_out <= front_sel_out ^ swap_fire;
            swap_done_out <= swap_fire;
            wr_en_out     <= fire & in_range;
            drop_out      <= fire & ~in_range;
            // Bank bit samples front_sel_out before any toggle on this same edge.
            if (fire && in_range) begin
                wr_addr_out <= {~front_sel_out, sel_addr};
                wr_data_out <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_fb_swap_arbiter.sv
// Scoreboard bench for fb_swap_arbiter: a reference model predicts grants, swap
// behaviour and frame buffer writes; a negedge monitor pops and compares writes.
module tb_fb_swap_arbiter;

    typedef struct {
        logic        drop;
        logic [16:0] addr;
        logic [15:0] data;
    } exp_t;

    logic        clk_in;
    logic        rst_in;
    logic [1:0]  req_valid_in;
    logic [15:0] req_addr0_in, req_addr1_in;
    logic [15:0] req_data0_in, req_data1_in;
    logic [1:0]  req_ready_out;
    logic        wr_en_out;
    logic [16:0] wr_addr_out;
    logic [15:0] wr_data_out;
    logic        swap_req_in, nf_in;
    logic        front_sel_out, swap_busy_out, swap_done_out, drop_out;

    exp_t        sb[$];
    int          n_chk;
    int          n_fail;
    logic        m_ptr, m_front, m_pend;
    logic [16:0] last_addr;
    logic [15:0] last_data;

    fb_swap_arbiter #(.ADDR_W(16), .DATA_W(16), .FB_DEPTH(57600)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_in(req_valid_in),
        .req_addr0_in(req_addr0_in), .req_addr1_in(req_addr1_in),
        .req_data0_in(req_data0_in), .req_data1_in(req_data1_in),
        .req_ready_out(req_ready_out),
        .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
        .swap_req_in(swap_req_in), .nf_in(nf_in),
        .front_sel_out(front_sel_out), .swap_busy_out(swap_busy_out),
        .swap_done_out(swap_done_out), .drop_out(drop_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Write-port monitor: every strobe or drop must match the oldest expected beat.
    always @(negedge clk_in) begin
        exp_t e;
        if (rst_in) begin
            if (wr_en_out || drop_out) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: wr_en=%b drop=%b, expected no activity", wr_en_out, drop_out);
                end else begin
                    e = sb.pop_front();
                    if (drop_out !== e.drop || wr_en_out !== !e.drop) begin
                        n_fail++;
                        $display("FAIL write_kind: wr_en=%b drop=%b, expected wr_en=%b drop=%b",
                                 wr_en_out, drop_out, !e.drop, e.drop);
                    end
                    if (!e.drop) begin
                        n_chk++;
                        if (wr_addr_out !== e.addr || wr_data_out !== e.data) begin
                            n_fail++;
                            $display("FAIL write_data: addr=%h data=%h, expected addr=%h data=%h",
                                     wr_addr_out, wr_data_out, e.addr, e.data);
                        end
                        last_addr = e.addr;
                        last_data = e.data;
                    end
                end
            end else begin
                n_chk++;
                if (wr_addr_out !== last_addr || wr_data_out !== last_data) begin
                    n_fail++;
                    $display("FAIL write_hold: addr=%h data=%h, expected addr=%h data=%h",
                             wr_addr_out, wr_data_out, last_addr, last_data);
                end
            end
        end
    end

    // One clock of stimulus: predict ready/busy before the edge, front/done after it.
    task automatic drive_cycle(input logic [1:0] v, input logic [15:0] a0, input logic [15:0] d0,
                               input logic [15:0] a1, input logic [15:0] d1,
                               input logic swp, input logic nf);
        logic [1:0]  exp_rdy;
        logic        exp_done;
        logic        s;
        logic [15:0] a;
        exp_t        e;
        req_valid_in = v;
        req_addr0_in = a0; req_data0_in = d0;
        req_addr1_in = a1; req_data1_in = d1;
        swap_req_in  = swp;
        nf_in        = nf;
        #1;
        exp_rdy = 2'b00;
        if (!m_pend) begin
            if (v[m_ptr])       exp_rdy[m_ptr]  = 1'b1;
            else if (v[~m_ptr]) exp_rdy[~m_ptr] = 1'b1;
        end
        n_chk++;
        if (req_ready_out !== exp_rdy) begin
            n_fail++;
            $display("FAIL ready: got %b, expected %b", req_ready_out, exp_rdy);
        end
        n_chk++;
        if (swap_busy_out !== m_pend) begin
            n_fail++;
            $display("FAIL busy: got %b, expected %b", swap_busy_out, m_pend);
        end
        if (exp_rdy != 2'b00) begin
            s      = exp_rdy[1];
            a      = s ? a1 : a0;
            e.drop = (int'(a) >= 57600);
            e.addr = {~m_front, a};
            e.data = s ? d1 : d0;
            sb.push_back(e);
            m_ptr = ~s;
        end
        exp_done = m_pend && nf;
        if (!m_pend && swp) m_pend = 1'b1;
        else if (m_pend && nf) begin
            m_pend  = 1'b0;
            m_front = ~m_front;
        end
        @(posedge clk_in);
        #1;
        n_chk++;
        if (front_sel_out !== m_front || swap_done_out !== exp_done) begin
            n_fail++;
            $display("FAIL swap_state: front=%b done=%b, expected front=%b done=%b",
                     front_sel_out, swap_done_out, m_front, exp_done);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive_cycle(2'b00, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        n_chk++;
        if (req_ready_out !== 2'b00 || wr_en_out !== 1'b0 || wr_addr_out !== '0 ||
            wr_data_out !== '0 || front_sel_out !== 1'b0 || swap_busy_out !== 1'b0 ||
            swap_done_out !== 1'b0 || drop_out !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: rdy=%b en=%b addr=%h data=%h front=%b busy=%b done=%b drop=%b, expected all 0",
                     tag, req_ready_out, wr_en_out, wr_addr_out, wr_data_out,
                     front_sel_out, swap_busy_out, swap_done_out, drop_out);
        end
    endtask

    task automatic model_reset();
        m_ptr     = 1'b0;
        m_front   = 1'b0;
        m_pend    = 1'b0;
        last_addr = '0;
        last_data = '0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        model_reset();
        req_valid_in = 2'b11;
        req_addr0_in = 16'd5; req_addr1_in = 16'd6;
        req_data0_in = 16'h1111; req_data1_in = 16'h2222;
        swap_req_in = 1'b1;
        nf_in = 1'b1;
        #2;
        check_all_zero("reset_async");
        @(posedge clk_in);
        #1;
        check_all_zero("reset_held");
        #2;
        rst_in = 1'b1;
        swap_req_in = 1'b0;
        nf_in = 1'b0;
        req_valid_in = 2'b00;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 4; i++)
            drive_cycle(2'b11, 16'(i), 16'hA000 + 16'(i), 16'(i), 16'hB000 + 16'(i), 1'b0, 1'b0);
        idle_cycles(2);
    endtask

    task automatic test_single_write();
        drive_cycle(2'b01, 16'd100, 16'hBEEF, 16'd0, 16'd0, 1'b0, 1'b0);
        drive_cycle(2'b10, 16'd0, 16'd0, 16'd200, 16'hCAFE, 1'b0, 1'b0);
        drive_cycle(2'b10, 16'd0, 16'd0, 16'd201, 16'hCAFF, 1'b0, 1'b0);
        idle_cycles(2);
    endtask

    task automatic test_swap_delayed();
        drive_cycle(2'b00, '0, '0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++)
            drive_cycle(2'b11, 16'd7, 16'h0707, 16'd8, 16'h0808, 1'b0, 1'b0);
        drive_cycle(2'b11, 16'd7, 16'h0707, 16'd8, 16'h0808, 1'b0, 1'b1);
        drive_cycle(2'b01, 16'd300, 16'h1234, 16'd0, 16'd0, 1'b1, 1'b0);
        idle_cycles(2);
    endtask

    task automatic test_swap_same_cycle();
        drive_cycle(2'b00, '0, '0, '0, '0, 1'b1, 1'b0);
        drive_cycle(2'b00, '0, '0, '0, '0, 1'b1, 1'b1);
        drive_cycle(2'b01, 16'd400, 16'h4444, 16'd0, 16'd0, 1'b1, 1'b1);
        drive_cycle(2'b00, '0, '0, '0, '0, 1'b0, 1'b0);
        drive_cycle(2'b00, '0, '0, '0, '0, 1'b0, 1'b1);
        drive_cycle(2'b11, 16'd9, 16'h0909, 16'd10, 16'h1010, 1'b0, 1'b1);
        idle_cycles(2);
    endtask

    task automatic test_out_of_range();
        drive_cycle(2'b01, 16'd57600, 16'hDEAD, 16'd0, 16'd0, 1'b0, 1'b0);
        idle_cycles(1);
        drive_cycle(2'b01, 16'd57599, 16'hF00D, 16'd0, 16'd0, 1'b0, 1'b0);
        drive_cycle(2'b11, 16'hFFFF, 16'h5555, 16'd57600, 16'h6666, 1'b0, 1'b0);
        drive_cycle(2'b11, 16'hFFFF, 16'h5555, 16'd57600, 16'h6666, 1'b0, 1'b0);
        idle_cycles(2);
    endtask

    task automatic test_reset_mid_swap();
        drive_cycle(2'b00, '0, '0, '0, '0, 1'b1, 1'b0);
        drive_cycle(2'b00, '0, '0, '0, '0, 1'b0, 1'b1);
        drive_cycle(2'b01, 16'd50, 16'h5050, 16'd0, 16'd0, 1'b1, 1'b0);
        idle_cycles(2);
        req_valid_in = 2'b11;
        #2;
        rst_in = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset_mid_swap");
        nf_in = 1'b1;
        @(posedge clk_in);
        #1;
        check_all_zero("reset_mid_swap_held");
        nf_in = 1'b0;
        rst_in = 1'b1;
        #1;
        n_chk++;
        if (req_ready_out !== 2'b01 || front_sel_out !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_grant: rdy=%b front=%b, expected rdy=01 front=0",
                     req_ready_out, front_sel_out);
        end
        drive_cycle(2'b11, 16'd60, 16'h6060, 16'd61, 16'h6161, 1'b0, 1'b0);
        drive_cycle(2'b11, 16'd62, 16'h6262, 16'd63, 16'h6363, 1'b0, 1'b0);
        idle_cycles(2);
    endtask

    task automatic test_random();
        logic [15:0] a0, a1;
        for (int i = 0; i < 200; i++) begin
            a0 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(57595, 57605)) : 16'($urandom);
            a1 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(57595, 57605)) : 16'($urandom);
            drive_cycle(2'($urandom_range(0, 3)), a0, 16'($urandom), a1, 16'($urandom),
                        ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
        end
        idle_cycles(3);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_round_robin();
        test_single_write();
        test_swap_delayed();
        test_swap_same_cycle();
        test_out_of_range();
        test_reset_mid_swap();
        test_random();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d beats outstanding, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
